// File: rtl/idex_pipe_buffer.sv
// Elastic decode-to-execute pipeline buffer with valid/ready handshakes on both sides.
// It holds FFT block instructions at the head while the accelerator is busy, can be
// flushed on a taken branch or jump, and counts the cycles lost to the FFT interlock.
module idex_pipe_buffer #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       CTRL_W    = 16,
    parameter int unsigned       DEPTH     = 2,
    parameter int unsigned       STALL_W   = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h08000000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [DATA_W-1:0]        in_pcPlus4,
    input  logic [DATA_W-1:0]        in_read1Data,
    input  logic [DATA_W-1:0]        in_read2Data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic                     in_block,
    input  logic                     fftCalculating,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [DATA_W-1:0]        out_pcPlus4,
    output logic [DATA_W-1:0]        out_read1Data,
    output logic [DATA_W-1:0]        out_read2Data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [$clog2(DEPTH):0]   count,
    output logic [STALL_W-1:0]       stallCycles
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pcPlus4;
        logic [DATA_W-1:0] read1Data;
        logic [DATA_W-1:0] read2Data;
        logic [CTRL_W-1:0] ctrl;
        logic              block;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   validQ;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   wptr;
    logic [CNT_W-1:0]   countQ;
    logic [STALL_W-1:0] stallQ;

    entry_t head;
    entry_t wrEntry;
    logic   notEmpty;
    logic   blocked;
    logic   push;
    logic   pop;

    // Handshake decode: head interlock, acceptance and issue.
    always_comb begin
        head     = mem[rptr];
        notEmpty = (countQ != '0) && validQ[rptr];
        blocked  = notEmpty && head.block && fftCalculating;
        in_ready = (countQ < CNT_W'(DEPTH)) && !flush;
        out_valid = rst && notEmpty && !blocked;
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wrEntry  = '{instr: in_instr, pcPlus4: in_pcPlus4, read1Data: in_read1Data,
                     read2Data: in_read2Data, ctrl: in_ctrl, block: in_block};
    end

    // Head payload, or a NOP bubble when nothing is buffered.
    always_comb begin
        out_instr     = NOP_INSTR;
        out_pcPlus4   = '0;
        out_read1Data = '0;
        out_read2Data = '0;
        out_ctrl      = '0;
        if (rst && notEmpty) begin
            out_instr     = head.instr;
            out_pcPlus4   = head.pcPlus4;
            out_read1Data = head.read1Data;
            out_read2Data = head.read2Data;
            out_ctrl      = head.ctrl;
        end
    end

    // Payload storage; needs no reset because the valid bits qualify every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wrEntry;
        end
    end

    // Pointers, occupancy, valid bits and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr   <= '0;
            wptr   <= '0;
            countQ <= '0;
            validQ <= '0;
            stallQ <= '0;
        end else begin
            if (blocked && (stallQ != '1)) begin
                stallQ <= stallQ + STALL_W'(1);
            end
            if (flush) begin
                rptr   <= '0;
                wptr   <= '0;
                countQ <= '0;
                validQ <= '0;
            end else begin
                if (push) begin
                    validQ[wptr] <= 1'b1;
                    wptr         <= wptr + PTR_W'(1);
                end
                if (pop) begin
                    validQ[rptr] <= 1'b0;
                    rptr         <= rptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   countQ <= countQ + CNT_W'(1);
                    2'b01:   countQ <= countQ - CNT_W'(1);
                    default: countQ <= countQ;
                endcase
            end
        end
    end

    assign count       = countQ;
    assign stallCycles = stallQ;

endmodule

// File: tb/tb_idex_pipe_buffer.sv
// Randomized bench for idex_pipe_buffer against a queue-based reference model.
module tb_idex_pipe_buffer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 16;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned STALL_W = 4;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int          STALL_MAX = (1 << STALL_W) - 1;
    localparam logic [31:0] NOP     = 32'h08000000;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pcPlus4;
    logic [DATA_W-1:0] in_read1Data;
    logic [DATA_W-1:0] in_read2Data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_block;
    logic              fftCalculating;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pcPlus4;
    logic [DATA_W-1:0] out_read1Data;
    logic [DATA_W-1:0] out_read2Data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  count;
    logic [STALL_W-1:0] stallCycles;

    idex_pipe_buffer #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .STALL_W(STALL_W),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pcPlus4(in_pcPlus4),
        .in_read1Data(in_read1Data), .in_read2Data(in_read2Data),
        .in_ctrl(in_ctrl), .in_block(in_block),
        .fftCalculating(fftCalculating), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pcPlus4(out_pcPlus4),
        .out_read1Data(out_read1Data), .out_read2Data(out_read2Data),
        .out_ctrl(out_ctrl), .count(count), .stallCycles(stallCycles)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [15:0] ctrl;
        logic        blk;
    } ent_t;

    ent_t q[$];
    int   stall = 0;
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model for the inputs currently driven, then advance the model.
    task automatic step_check();
        ent_t h;
        bit   empty;
        bit   blk;
        bit   ev;
        bit   er;
        empty = (q.size() == 0);
        blk   = !empty && q[0].blk && fftCalculating;
        ev    = rst && !empty && !blk;
        er    = (q.size() < DEPTH) && !flush;
        check("in_ready",    64'(in_ready),    64'(er));
        check("out_valid",   64'(out_valid),   64'(ev));
        check("count",       64'(count),       64'(q.size()));
        check("stallCycles", 64'(stallCycles), 64'(stall));
        if (rst && !empty) begin
            h = q[0];
            check("out_instr", 64'(out_instr),     64'(h.instr));
            check("out_pc",    64'(out_pcPlus4),   64'(h.pc));
            check("out_r1",    64'(out_read1Data), 64'(h.r1));
            check("out_r2",    64'(out_read2Data), 64'(h.r2));
            check("out_ctrl",  64'(out_ctrl),      64'(h.ctrl));
        end else begin
            check("out_instr_nop", 64'(out_instr), 64'(NOP));
            check("out_data_zero", 64'({out_pcPlus4, out_read1Data}) | 64'(out_read2Data) | 64'(out_ctrl), 64'(0));
        end
        if (!rst) begin
            q.delete();
            stall = 0;
        end else begin
            if (blk) stall = (stall < STALL_MAX) ? stall + 1 : STALL_MAX;
            if (flush) begin
                q.delete();
            end else begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && er) begin
                    h = '{instr: in_instr, pc: in_pcPlus4, r1: in_read1Data,
                          r2: in_read2Data, ctrl: in_ctrl, blk: in_block};
                    q.push_back(h);
                end
            end
        end
    endtask

    // Random cycles with per-signal assertion probabilities in percent.
    task automatic run(input int n, input int pv, input int pr, input int pb,
                       input int pf, input int pfl, input int prst);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst            = !($urandom_range(99) < prst);
            in_valid       = $urandom_range(99) < pv;
            out_ready      = $urandom_range(99) < pr;
            in_block       = $urandom_range(99) < pb;
            fftCalculating = $urandom_range(99) < pf;
            flush          = $urandom_range(99) < pfl;
            seq++;
            in_instr       = 32'h20000000 + 32'(seq);
            in_pcPlus4     = $urandom;
            in_read1Data   = $urandom;
            in_read2Data   = $urandom;
            in_ctrl        = 16'($urandom);
            #1;
            step_check();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_block = 1'b0;
        fftCalculating = 1'b0; flush = 1'b0;
        in_instr = 32'h20000000; in_pcPlus4 = '0; in_read1Data = '0;
        in_read2Data = '0; in_ctrl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        step_check();

        run(300, 100, 100,   0,   0,  0,   0);
        run(200,  80,  20,   0,   0,  0,   0);
        run(300,  60,  80,  40,  50,  0,   0);
        run(2,     0,   0,   0,   0,  0, 100);
        run(30,  100, 100, 100, 100,  0,   0);
        run(300,  70,  70,  30,  30, 10,   0);
        run(600,  70,  70,  30,  30, 10,   3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idex_pipe_buffer.md
Name: idex_pipe_buffer

Overview:
- Parametrised, elastic decode-to-execute pipeline buffer for the FFT-controlling CPU.
- Replaces the direct combinational decode→execute hookup with a DEPTH-entry FIFO using valid/ready handshakes on both sides.
- Holds FFT block instructions (startI/startF/loadF class) at the head while the accelerator is busy.
- Supports a branch/jump flush and counts FFT-interlock stall cycles.

Parameters:
DATA_W, 32, width of instr, pcPlus4, read1Data, read2Data
CTRL_W, 16, width of packed decode control bundle (aluOp, aluSrc, isBranch, isJump, isJR, isSLBI, mem*, halt, start*/loadF, etc.)
DEPTH, 2, FIFO entries; power of two, ≥2
STALL_W, 16, width of stall counter
NOP_INSTR, 32'h08000000, instruction presented when buffer is empty

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
in_valid  input  1  decode presents a valid instruction bundle
in_ready  output  1  buffer accepts the bundle this cycle
in_instr  input  DATA_W  instruction
in_pcPlus4  input  DATA_W  PC+4
in_read1Data  input  DATA_W  register read port 1
in_read2Data  input  DATA_W  register read port 2
in_ctrl  input  CTRL_W  packed decode control
in_block  input  1  entry is an FFT block instruction (blockInstruction)
fftCalculating  input  1  accelerator busy
flush  input  1  discard all buffered entries (taken branch/jump)
out_valid  output  1  head entry available to execute
out_ready  input  1  execute consumes head entry
out_instr  output  DATA_W  head instruction
out_pcPlus4  output  DATA_W  head PC+4
out_read1Data  output  DATA_W  head read data 1
out_read2Data  output  DATA_W  head read data 2
out_ctrl  output  CTRL_W  head control bundle
count  output  $clog2(DEPTH)+1  current occupancy
stallCycles  output  STALL_W  saturating count of FFT-interlock stall cycles

Behaviour:
- Reset (rst==0 at posedge):
  - Read/write pointers 0, count 0, stallCycles 0.
  - All storage valid bits cleared.
  - Outputs while in reset and after: out_valid 0, out_instr NOP_INSTR; out_pcPlus4, out_read*, out_ctrl 0.
  - Reset mid-operation discards all entries the same edge; no partial state survives.
- Storage: circular FIFO; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- in_ready = (count < DEPTH) && !flush.
  - Registered-state only; no combinational path from out_ready, and a pop does not free a slot in the same cycle.
- push = in_valid && in_ready.
  - Writes the bundle plus in_block at wptr; wptr++.
- Head blocked = count>0 && head.block && fftCalculating.
- out_valid = count>0 && !blocked.
- pop = out_valid && out_ready.
  - Advances rptr; takes effect at the next edge.
- Output data is combinational from the head slot when count>0; otherwise NOP_INSTR and zeros.
  - Outputs are shown even while blocked; execute must qualify with out_valid.
- Latency: a bundle pushed at edge N is visible at the head, out_valid=1, from edge N+1 if the buffer was empty (one cycle).
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Flush:
  - A pop in the flush cycle completes.
  - Push is suppressed (in_ready=0).
  - At the next edge: count 0, rptr=wptr=0, all valid bits cleared.
- Flush and reset together: reset wins; results are identical.
- stallCycles:
  - Increments by 1 each cycle that blocked==1.
  - Saturates at 2^STALL_W−1.
  - Unaffected by flush; cleared only by reset.
- Ordering is strict FIFO: a blocked head blocks younger entries; there is no bypass.
- No overflow or underflow is possible by construction. A push while full or a pop while empty is ignored.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 → out_valid=0, out_instr=32'h08000000, count=0, stallCycles=0. Release rst=1 → first push appears one cycle later.
- Streaming: DEPTH=2, out_ready=1, push instr 0x20000001..0x20000008 on consecutive cycles → same order out, 1-cycle latency, count toggles 1; no drops. (in_ready drops every other cycle only if count reaches 2.)
- Backpressure/full: out_ready=0, push 3 bundles → count=2, in_ready=0 after 2; third held by source. out_ready=1 → 0x…01 then 0x…02 out, then third accepted.
- FFT interlock: head in_block=1, fftCalculating=1 for 5 cycles, out_ready=1 → out_valid=0 for 5 cycles, stallCycles=5, head stays. fftCalculating=0 → issued next cycle.
- Flush: count=2, pulse flush with out_ready=1 → head popped that cycle; next cycle count=0, out_valid=0, out_instr=NOP; in_ready=0 during the flush cycle.
- Saturation/wrap: STALL_W=4, block 20 cycles → stallCycles=15. Then push/pop 2×DEPTH+1 entries → pointer wrap with data intact.
